fm_logo_arbiter: RTL and testbench



---
 rtl/fm_logo_arbiter.sv | 154 +++++++++++++++
 tb/tb_fm_logo_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_logo_arbiter.sv
// fm_logo_arbiter
// ---------------
// Shares the single-port FM logo RAM (1-cycle registered read, read-first on
// write) between the video fetch port and the CPU/MSX bus port.
//
// Video has priority. The CPU gets a guaranteed grant after CPU_STARVE_MAX
// consecutive deferred cycles. Read data returns to the owner of each read
// through a 2-deep tag pipeline. Valid pulses appear two cycles after
// acceptance, and back-to-back reads are fully pipelined.
//
// Configuration macro:
//   FM_LOGO_WRITE_EN  defined   : CPU writes reach the RAM.
//                     undefined : the RAM is write-protected ROM. CPU writes
//                                 are still acknowledged, but mem_wren is
//                                 held at 0.
//
// Ports:
//   clock, reset             system clock; synchronous active-high reset
//   vid_req/vid_addr         video read request and address
//   vid_ack                  video request accepted this cycle
//   vid_valid/vid_q          video read data, pulsed two cycles after accept
//   cpu_req/cpu_wr           CPU request; cpu_wr = 1 selects a write
//   cpu_addr/cpu_wdata       CPU address and write data
//   cpu_ack                  CPU request accepted this cycle
//   cpu_rvalid/cpu_rdata     CPU read data, pulsed two cycles after accept
//   mem_address/mem_data     RAM address and write data
//   mem_wren                 RAM write enable
//   mem_q                    RAM registered read data
module fm_logo_arbiter #(
  parameter int unsigned ADDR_W         = 14,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned CPU_STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_q,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  typedef enum logic [1:0] {
    TagNone = 2'd0,
    TagVid  = 2'd1,
    TagCpu  = 2'd2
  } tag_e;

  localparam logic [3:0] StarveMax = 4'(CPU_STARVE_MAX);

  logic              vid_win;
  logic              cpu_win;
  logic [3:0]        starve_q;
  logic [3:0]        starve_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  tag_e              tag_d;
  // tag_q[0]: read accepted last cycle, so mem_q is valid now.
  // tag_q[1]: read data was captured last cycle, so valid is high now.
  tag_e              tag_q [2];

  // Grant decision. Video wins a conflict unless the CPU has waited long enough.
  always_comb begin
    vid_win = 1'b0;
    cpu_win = 1'b0;
    if (!reset) begin
      if (cpu_req && (!vid_req || (starve_q == StarveMax))) begin
        cpu_win = 1'b1;
      end else if (vid_req) begin
        vid_win = 1'b1;
      end
    end
  end

  assign vid_ack = vid_win;
  assign cpu_ack = cpu_win;

  // With no winner, the RAM address keeps the last granted address.
  always_comb begin
    addr_d = addr_q;
    if (vid_win) begin
      addr_d = vid_addr;
    end else if (cpu_win) begin
      addr_d = cpu_addr;
    end
  end

  assign mem_address = addr_d;
  assign mem_data    = cpu_win ? cpu_wdata : '0;

`ifdef FM_LOGO_WRITE_EN
  assign mem_wren = cpu_win & cpu_wr;
`else
  assign mem_wren = 1'b0;
`endif

  // Starvation counter. It counts consecutive cycles in which the CPU asked
  // but was not granted.
  always_comb begin
    starve_d = 4'd0;
    if (cpu_req && !cpu_win) begin
      starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 4'd1;
    end
  end

  // Writes and idle cycles put a bubble in the read pipeline.
  always_comb begin
    tag_d = TagNone;
    if (vid_win) begin
      tag_d = TagVid;
    end else if (cpu_win && !cpu_wr) begin
      tag_d = TagCpu;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q  <= 4'd0;
      addr_q    <= '0;
      tag_q[0]  <= TagNone;
      tag_q[1]  <= TagNone;
      vid_q     <= '0;
      cpu_rdata <= '0;
    end else begin
      starve_q <= starve_d;
      addr_q   <= addr_d;
      tag_q[0] <= tag_d;
      tag_q[1] <= tag_q[0];
      // Each data register updates only on a read by its own owner and
      // holds otherwise.
      if (tag_q[0] == TagVid) begin
        vid_q <= mem_q;
      end
      if (tag_q[0] == TagCpu) begin
        cpu_rdata <= mem_q;
      end
    end
  end

  assign vid_valid  = (tag_q[1] == TagVid);
  assign cpu_rvalid = (tag_q[1] == TagCpu);

endmodule

// File: tb/tb_fm_logo_arbiter.sv
module tb_fm_logo_arbiter;

  localparam int AW = 14;
  localparam int DW = 8;
  localparam int SM = 4;
  localparam int Depth = 1 << AW;

  logic          clock = 1'b0;
  logic          reset;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_ack;
  logic          vid_valid;
  logic [DW-1:0] vid_q;
  logic          cpu_req;
  logic          cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data;
  logic          mem_wren;
  logic [DW-1:0] mem_q;

  fm_logo_arbiter #(
    .ADDR_W        (AW),
    .DATA_W        (DW),
    .CPU_STARVE_MAX(SM)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_ack    (vid_ack),
    .vid_valid  (vid_valid),
    .vid_q      (vid_q),
    .cpu_req    (cpu_req),
    .cpu_wr     (cpu_wr),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .mem_address(mem_address),
    .mem_data   (mem_data),
    .mem_wren   (mem_wren),
    .mem_q      (mem_q)
  );

  always #5 clock = ~clock;

  // Logo RAM: single port, registered read, read-first on write.
  logic [DW-1:0] ram [Depth];
  always @(posedge clock) begin
    mem_q <= ram[mem_address];
    if (mem_wren) ram[mem_address] <= mem_data;
  end

  // Reference model: the expected RAM contents.
  logic [DW-1:0] ref_mem [Depth];

  function automatic logic [DW-1:0] init_byte(int a);
    return 8'((a * 37 + (a >> 5)) ^ 8'h5A);
  endfunction

  int cycle = 0;
  always @(posedge clock) cycle++;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
  endtask

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } exp_t;

  exp_t vid_exp[$];
  exp_t cpu_exp[$];

  // Monitor: pops the scoreboard whenever the DUT presents read data.
  logic [DW-1:0] vid_hold = '0;
  logic [DW-1:0] cpu_hold = '0;
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      vid_hold = '0;
      cpu_hold = '0;
    end else begin
      if (vid_valid || cpu_rvalid) check("valid_overlap", 32'(vid_valid & cpu_rvalid), 0);
      if (vid_valid) begin
        if (vid_exp.size() == 0) check("vid_valid_unexpected", 32'(vid_valid), 0);
        else begin
          e = vid_exp.pop_front();
          check("vid_valid_cycle", cycle, e.cyc);
          check("vid_q", 32'(vid_q), 32'(e.data));
          vid_hold = e.data;
        end
      end else begin
        if (vid_exp.size() > 0 && vid_exp[0].cyc <= cycle) begin
          check("vid_valid_missing", 32'(vid_valid), 1);
          void'(vid_exp.pop_front());
        end
        check("vid_q_hold", 32'(vid_q), 32'(vid_hold));
      end
      if (cpu_rvalid) begin
        if (cpu_exp.size() == 0) check("cpu_rvalid_unexpected", 32'(cpu_rvalid), 0);
        else begin
          e = cpu_exp.pop_front();
          check("cpu_rvalid_cycle", cycle, e.cyc);
          check("cpu_rdata", 32'(cpu_rdata), 32'(e.data));
          cpu_hold = e.data;
        end
      end else begin
        if (cpu_exp.size() > 0 && cpu_exp[0].cyc <= cycle) begin
          check("cpu_rvalid_missing", 32'(cpu_rvalid), 1);
          void'(cpu_exp.pop_front());
        end
        check("cpu_rdata_hold", 32'(cpu_rdata), 32'(cpu_hold));
      end
    end
  end

  // Arbitration model state.
  int            deferred = 0;   // consecutive cycles the CPU asked and was refused
  logic [AW-1:0] last_addr = '0;
  logic          got_vid = 1'b0;
  logic          got_cpu = 1'b0;

  // One clock cycle: inputs were driven after the previous posedge; check at negedge.
  task automatic step();
    logic e_vid, e_cpu, e_wren;
    exp_t e;
    @(negedge clock);
    e_cpu = !reset && cpu_req && (!vid_req || deferred >= SM);
    e_vid = !reset && vid_req && !e_cpu;
`ifdef FM_LOGO_WRITE_EN
    e_wren = e_cpu && cpu_wr;
`else
    e_wren = 1'b0;
`endif
    check("vid_ack", 32'(vid_ack), 32'(e_vid));
    check("cpu_ack", 32'(cpu_ack), 32'(e_cpu));
    check("mem_wren", 32'(mem_wren), 32'(e_wren));
    if (e_vid) check("mem_address_vid", 32'(mem_address), 32'(vid_addr));
    else if (e_cpu) begin
      check("mem_address_cpu", 32'(mem_address), 32'(cpu_addr));
      if (cpu_wr) check("mem_data", 32'(mem_data), 32'(cpu_wdata));
    end else if (!reset) check("mem_address_hold", 32'(mem_address), 32'(last_addr));

    if (e_vid) begin
      e.cyc = cycle + 2;
      e.data = ref_mem[vid_addr];
      vid_exp.push_back(e);
      last_addr = vid_addr;
    end
    if (e_cpu) begin
      last_addr = cpu_addr;
      if (cpu_wr) begin
`ifdef FM_LOGO_WRITE_EN
        ref_mem[cpu_addr] = cpu_wdata;
`endif
      end else begin
        e.cyc = cycle + 2;
        e.data = ref_mem[cpu_addr];
        cpu_exp.push_back(e);
      end
    end
    if (reset || !cpu_req || e_cpu) deferred = 0;
    else deferred++;
    if (reset) begin
      vid_exp.delete();
      cpu_exp.delete();
      last_addr = '0;
    end
    got_vid = e_vid;
    got_cpu = e_cpu;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    vid_req = 1'b0;
    cpu_req = 1'b0;
    cpu_wr  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [DW-1:0] exp_wr;
    for (int i = 0; i < Depth; i++) begin
      ram[i]     = init_byte(i);
      ref_mem[i] = init_byte(i);
    end
    reset = 1'b1;
    idle();
    vid_addr  = '0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    @(posedge clock);
    #1;
    repeat (3) step();
    reset = 1'b0;

    // Reset values, then 20 idle cycles.
    @(negedge clock);
    check("rst_vid_valid", 32'(vid_valid), 0);
    check("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
    check("rst_vid_q", 32'(vid_q), 0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 0);
    check("rst_mem_address", 32'(mem_address), 0);
    @(posedge clock);
    #1;
    repeat (20) step();

    // Single video read, then 8 back-to-back reads.
    vid_req = 1'b1;
    vid_addr = '0;
    step();
    idle();
    repeat (3) step();
    vid_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vid_addr = AW'(i);
      step();
    end
    idle();
    repeat (4) step();

    // CPU write 0x3FFF = 0xA5, then read it back.
    cpu_req = 1'b1;
    cpu_wr = 1'b1;
    cpu_addr = 14'h3FFF;
    cpu_wdata = 8'hA5;
    step();
    cpu_wr = 1'b0;
    step();
    idle();
    step();
`ifdef FM_LOGO_WRITE_EN
    exp_wr = 8'hA5;
`else
    exp_wr = init_byte(14'h3FFF);
`endif
    check("wr_then_rd_3fff", 32'(cpu_rdata), 32'(exp_wr));
    repeat (3) step();

    // Starvation: video held busy, CPU read of 0x0100 is forced through.
    vid_req = 1'b1;
    vid_addr = 14'h0040;
    cpu_req = 1'b1;
    cpu_wr = 1'b0;
    cpu_addr = 14'h0100;
    n = 0;
    got_cpu = 1'b0;
    while (!got_cpu && n < 20) begin
      step();
      n++;
      if (got_vid) vid_addr = vid_addr + 1'b1;
    end
    check("starve_grant_cycle", n, SM + 1);
    cpu_req = 1'b0;
    step();
    check("starve_vid_ack_after", 32'(got_vid), 1);
    idle();
    repeat (4) step();

    // Reset one cycle after accepting a video read.
    vid_req = 1'b1;
    vid_addr = 14'h0005;
    step();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (4) step();
    check("mid_reset_vid_q", 32'(vid_q), 0);
    vid_req = 1'b1;
    vid_addr = 14'h0006;
    step();
    idle();
    repeat (3) step();

    // Randomized mixed traffic; requests held until acknowledged.
    got_vid = 1'b0;
    got_cpu = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (!vid_req || got_vid) begin
        vid_req = ($urandom_range(0, 99) < 60);
        vid_addr = AW'($urandom_range(0, 15));
      end
      if (!cpu_req || got_cpu) begin
        cpu_req = ($urandom_range(0, 99) < 50);
        cpu_wr = ($urandom_range(0, 2) == 0);
        cpu_addr = AW'($urandom_range(0, 15));
        cpu_wdata = DW'($urandom);
      end
      step();
    end
    idle();
    repeat (5) step();
    check("vid_drain", vid_exp.size(), 0);
    check("cpu_drain", cpu_exp.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
